interval_meter: RTL
===================

Name: interval_meter

Overview:
- Measuring counterpart to the one-shot timer: the timer emits a pulse a fixed number of cycles after a start request; this block measures the number of cycles between a START event and a STOP event.
- Reports the measured cycle count with a one-cycle VALID strobe.
- Saturates with an OVERFLOW flag when STOP never arrives.
- Used to time handshake latencies and pulse spacing between timer instances and other control FSMs.

Parameters:
- MAX_COUNT, 21'h1F_FFFF, largest reportable interval in cycles; reaching it without STOP ends the measurement as overflow. Legal range 1..21'h1F_FFFF.

Ports:
- CLK  input  1  system clock, rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- CLR  input  1  synchronous clear; aborts any measurement.
- START  input  1  start event, level input, rising edge detected internally; synchronous to CLK.
- STOP  input  1  stop event, level input, rising edge detected internally; synchronous to CLK.
- COUNT  output  21  last captured interval; held until the next capture.
- VALID  output  1  one-cycle strobe; COUNT is updated in the same cycle.
- OVERFLOW  output  1  one-cycle strobe, asserted together with VALID when the measurement saturated.
- BUSY  output  1  high while a measurement is in progress.

Behaviour:
- One clock (CLK). Reset is asynchronous and active-low (RST_N). All state is registered.
- Reset values: COUNT=0, VALID=0, OVERFLOW=0, BUSY=0, state=IDLE, counter=0, edge-history registers=0.
- Edge detect:
  - start_edge = START & ~start_d; stop_edge = STOP & ~stop_d.
  - start_d and stop_d sample every cycle, including during CLR, so a level held high across CLR does not create a false edge afterwards.
- VALID and OVERFLOW default to 0 every cycle (pulsed).
- State IDLE:
  - start_edge -> COUNT state; counter <= 1; BUSY <= 1.
  - stop_edge alone is ignored.
  - start_edge and stop_edge in the same cycle: start is taken, stop is ignored.
- State COUNT:
  - counter increments each cycle. In cycle t+k after the start-edge cycle t, counter = k.
  - stop_edge (priority over overflow): COUNT <= counter, VALID <= 1, counter <= 0, BUSY <= 0, go IDLE.
  - Else if counter == MAX_COUNT: COUNT <= MAX_COUNT, VALID <= 1, OVERFLOW <= 1, counter <= 0, BUSY <= 0, go IDLE.
  - start_edge is ignored (no retrigger).
  - Result: STOP edge detected N cycles after the START edge gives COUNT=N. Minimum N=1; maximum non-overflow N=MAX_COUNT.
- Latency: VALID and COUNT appear on the first rising edge after the stop-edge cycle, i.e. registered one cycle after the edge is detected.
- Back-to-back: a start_edge in the cycle VALID is high is accepted, because the state is already IDLE.
- CLR (synchronous, below RST_N in priority):
  - state <= IDLE; counter, COUNT, VALID, OVERFLOW, BUSY <= 0.
  - No VALID is produced for an aborted measurement.
- Reset mid-measurement: all registers return to reset values immediately; no strobe is produced.
- Illegal state encodings return to IDLE on the next cycle.
- Counter width is 21 bits. The counter never exceeds MAX_COUNT, so there is no wrap-around.

Test Plan:
- MAX_COUNT=10. Reset, then START rises at cycle 5 and STOP rises at cycle 12 -> VALID=1 at cycle 13, COUNT=7, OVERFLOW=0, BUSY high during cycles 6..12.
- MAX_COUNT=10. START rises, STOP never rises -> VALID=1 and OVERFLOW=1 in the same cycle, COUNT=10, BUSY drops, state is IDLE; a new START is accepted.
- MAX_COUNT=10. STOP rises exactly when counter==10 -> COUNT=10, VALID=1, OVERFLOW=0 (stop wins). Separately, STOP one cycle after START -> COUNT=1.
- START and STOP rise together in IDLE -> measurement starts. STOP held high does not end it. STOP falls and rises 4 cycles after start -> COUNT=4. A STOP pulse in IDLE produces no VALID.
- Mid-measurement: assert CLR for 1 cycle -> BUSY=0, COUNT=0, no VALID. START held high through CLR produces no new measurement. Assert RST_N low asynchronously mid-count -> all outputs 0 before the next clock edge.
- Back-to-back: new START edge in the VALID cycle -> second measurement starts, and its COUNT equals the second interval exactly. Extra START edges during COUNT do not alter the result.

Source files
------------

// File: rtl/interval_meter_if.sv
// Control and result bundle of interval_meter: start/stop/clear events in,
// measured interval with its strobes out.
interface interval_meter_if;
   localparam int unsigned COUNT_W = 21;

   logic               clr;
   logic               start;
   logic               stop;
   logic [COUNT_W-1:0] count;
   logic               valid;
   logic               overflow;
   logic               busy;

   // master issues events and observes results; slave is the meter itself
   modport master (
      output clr, start, stop,
      input  count, valid, overflow, busy
   );

   modport slave (
      input  clr, start, stop,
      output count, valid, overflow, busy
   );
endinterface

// File: rtl/interval_meter.sv
// Measures the number of clk cycles from a START rising edge to a STOP rising
// edge; reports it with a one-cycle valid strobe, saturating at MAX_COUNT.
module interval_meter #(
   parameter logic [20:0] MAX_COUNT = 21'h1F_FFFF
) (
   input  logic             clk,
   input  logic             rst_n,
   interval_meter_if.slave  bus
);
   localparam int unsigned COUNT_W = 21;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_COUNT = 2'b01
   } state_t;

   state_t             state;
   state_t             state_next;

   logic               start_d;
   logic               stop_d;
   logic               start_edge;
   logic               stop_edge;
   logic               at_max;

   logic [COUNT_W-1:0] counter;
   logic [COUNT_W-1:0] counter_next;
   logic [COUNT_W-1:0] count_q;
   logic [COUNT_W-1:0] count_next;
   logic               valid_q;
   logic               valid_next;
   logic               overflow_q;
   logic               overflow_next;
   logic               busy_q;
   logic               busy_next;

   // Edge history samples every cycle, clear included, so a held level never re-triggers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         start_d <= 1'b0;
         stop_d  <= 1'b0;
      end else begin
         start_d <= bus.start;
         stop_d  <= bus.stop;
      end
   end

   assign start_edge = bus.start & ~start_d;
   assign stop_edge  = bus.stop  & ~stop_d;
   assign at_max     = (counter == MAX_COUNT);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic; stop takes priority over saturation, start never retriggers
   always_comb begin
      state_next = state;
      if (bus.clr) begin
         state_next = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start_edge) begin
                  state_next = ST_COUNT;
               end
            end
            ST_COUNT: begin
               if (stop_edge || at_max) begin
                  state_next = ST_IDLE;
               end
            end
            default: state_next = ST_IDLE;
         endcase
      end
   end

   // Output/datapath next values; registered below
   always_comb begin
      counter_next  = counter;
      count_next    = count_q;
      valid_next    = 1'b0;
      overflow_next = 1'b0;
      busy_next     = busy_q;
      if (bus.clr) begin
         counter_next = '0;
         count_next   = '0;
         busy_next    = 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start_edge) begin
                  counter_next = COUNT_W'(1);
                  busy_next    = 1'b1;
               end
            end
            ST_COUNT: begin
               if (stop_edge) begin
                  count_next   = counter;
                  valid_next   = 1'b1;
                  counter_next = '0;
                  busy_next    = 1'b0;
               end else if (at_max) begin
                  count_next    = MAX_COUNT;
                  valid_next    = 1'b1;
                  overflow_next = 1'b1;
                  counter_next  = '0;
                  busy_next     = 1'b0;
               end else begin
                  counter_next = counter + COUNT_W'(1);
               end
            end
            default: begin
               counter_next = '0;
               busy_next    = 1'b0;
            end
         endcase
      end
   end

   // Registered datapath and outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         counter    <= '0;
         count_q    <= '0;
         valid_q    <= 1'b0;
         overflow_q <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         counter    <= counter_next;
         count_q    <= count_next;
         valid_q    <= valid_next;
         overflow_q <= overflow_next;
         busy_q     <= busy_next;
      end
   end

   assign bus.count    = count_q;
   assign bus.valid    = valid_q;
   assign bus.overflow = overflow_q;
   assign bus.busy     = busy_q;

endmodule
